// File: rtl/button_conditioner_if.sv
// button_conditioner_if: key input, enable and conditioned event outputs of one board key.
// rev 1.0
`default_nettype none

interface button_conditioner_if;
   logic btn_n;
   logic enable;
   logic btn_state;
   logic pressed;
   logic released;
   logic long_press;
   logic held;
   logic repeat_pulse;

   modport master (
      output btn_n,
      output enable,
      input  btn_state,
      input  pressed,
      input  released,
      input  long_press,
      input  held,
      input  repeat_pulse
   );

   modport slave (
      input  btn_n,
      input  enable,
      output btn_state,
      output pressed,
      output released,
      output long_press,
      output held,
      output repeat_pulse
   );
endinterface

`default_nettype wire

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce, long-press and auto-repeat for one active-low key.
// Optional macro AUTO_REPEAT_EN enables repeat_pulse while held. rev 1.0
`default_nettype none

module button_conditioner #(
   parameter int DEBOUNCE_COUNT = 500_000,
   parameter int HOLD_COUNT     = 50_000_000,
   parameter int REPEAT_COUNT   = 12_500_000
) (
   input wire                  clk,
   input wire                  rst,
   button_conditioner_if.slave bus
);

   localparam int MAX_DH = (DEBOUNCE_COUNT > HOLD_COUNT) ? DEBOUNCE_COUNT : HOLD_COUNT;
   localparam int MAX_P  = (MAX_DH > REPEAT_COUNT) ? MAX_DH : REPEAT_COUNT;
   localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_COUNT - 1);
   localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_COUNT - 1);
`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_COUNT - 1);
`endif
   localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      DOWN     = 3'd2,
      LONG     = 3'd3,
      REL_DB   = 3'd4
   } state_t;

   logic [1:0]       sync_q;
   logic             w_sync;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             from_long_q;
   logic             btn_state_q;
   logic             held_q;
   logic             pressed_q;
   logic             released_q;
   logic             long_press_q;
`ifdef AUTO_REPEAT_EN
   logic             repeat_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], bus.btn_n};
      end
   end

   assign w_sync = ~sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         from_long_q  <= 1'b0;
         btn_state_q  <= 1'b0;
         held_q       <= 1'b0;
         pressed_q    <= 1'b0;
         released_q   <= 1'b0;
         long_press_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
         repeat_q     <= 1'b0;
`endif
      end else begin
         pressed_q    <= 1'b0;
         released_q   <= 1'b0;
         long_press_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
         repeat_q     <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (w_sync) begin
                  state_q <= PRESS_DB;
                  cnt_q   <= '0;
               end
            end
            PRESS_DB: begin
               if (!w_sync) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == c_DB_LAST) begin
                  state_q     <= DOWN;
                  cnt_q       <= '0;
                  btn_state_q <= 1'b1;
                  pressed_q   <= bus.enable;
               end else begin
                  cnt_q <= cnt_q + c_ONE;
               end
            end
            DOWN: begin
               if (!w_sync) begin
                  state_q     <= REL_DB;
                  cnt_q       <= '0;
                  from_long_q <= 1'b0;
               end else if (cnt_q == c_HOLD_LAST) begin
                  state_q      <= LONG;
                  cnt_q        <= '0;
                  held_q       <= 1'b1;
                  long_press_q <= bus.enable;
               end else begin
                  cnt_q <= cnt_q + c_ONE;
               end
            end
            LONG: begin
               if (!w_sync) begin
                  state_q     <= REL_DB;
                  cnt_q       <= '0;
                  from_long_q <= 1'b1;
`ifdef AUTO_REPEAT_EN
               end else if (cnt_q == c_REP_LAST) begin
                  cnt_q    <= '0;
                  repeat_q <= bus.enable;
               end else begin
                  cnt_q <= cnt_q + c_ONE;
               end
`else
               end else if (cnt_q != c_HOLD_LAST) begin
                  cnt_q <= cnt_q + c_ONE;
               end
`endif
            end
            REL_DB: begin
               // A bounce back to pressed resumes the origin state with fresh timing
               if (w_sync) begin
                  state_q <= from_long_q ? LONG : DOWN;
                  cnt_q   <= '0;
               end else if (cnt_q == c_DB_LAST) begin
                  state_q     <= IDLE;
                  cnt_q       <= '0;
                  from_long_q <= 1'b0;
                  btn_state_q <= 1'b0;
                  held_q      <= 1'b0;
                  released_q  <= bus.enable;
               end else begin
                  cnt_q <= cnt_q + c_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.btn_state    = btn_state_q;
   assign bus.pressed      = pressed_q;
   assign bus.released     = released_q;
   assign bus.long_press   = long_press_q;
   assign bus.held         = held_q;
`ifdef AUTO_REPEAT_EN
   assign bus.repeat_pulse = repeat_q;
`else
   assign bus.repeat_pulse = 1'b0;
`endif

endmodule

`default_nettype wire
